// File: rtl/line_prefetch_reader_if.sv
// Word-read bus between the scanline prefetcher (master) and the framebuffer memory (slave).
// A raised mem_req holds mem_addr stable until mem_ack; mem_rdata is valid with mem_ack.
interface line_prefetch_reader_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/line_prefetch_reader.sv
// Double-buffered scanline reader: bursts line N+1 from memory into one bank while
// line N is shifted out of the other bank, one pixel per newpixel strobe.
module line_prefetch_reader #(
   parameter int PIXELS_PER_LINE = 256,
   parameter int PIXEL_WIDTH     = 8,
   parameter int DATA_WIDTH      = 16,
   parameter int ADDR_WIDTH      = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   newframe,
   input  logic                   newline,
   input  logic                   newpixel,
   input  logic                   visible_line,
   input  logic                   visible_window,
   input  logic [8:0]             v_active,
   input  logic [ADDR_WIDTH-1:0]  fb_base,
   line_prefetch_reader_if.master mem,
   output logic [PIXEL_WIDTH-1:0] pixel,
   output logic                   pixel_valid,
   output logic                   underrun
);

   localparam int WORDS_PER_LINE = PIXELS_PER_LINE * PIXEL_WIDTH / DATA_WIDTH;
   localparam int PIX_PER_WORD   = DATA_WIDTH / PIXEL_WIDTH;
   localparam int WIDX_W         = $clog2(WORDS_PER_LINE);
   localparam int PX_W           = $clog2(PIXELS_PER_LINE);
   localparam int ROW_W          = 9;

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t                  state, state_nxt;
   logic [WIDX_W-1:0]       word_idx;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [ROW_W-1:0]        fetch_row;
   logic                    fetch_bank, display_bank, burst_bank;
   logic                    abort_pend, start_pend;
   logic [PX_W-1:0]         pixel_x;
   logic [DATA_WIDTH-1:0]   line_buf [2*WORDS_PER_LINE];

   logic                    ev_a, ev_b, ev_any, ev_start;
   logic [ADDR_WIDTH-1:0]   nxt_base, row_addr;
   logic [ROW_W-1:0]        nxt_row;
   logic                    nxt_bank;
   logic                    ack, last_word, launch, restart, burst_end;
   logic [WIDX_W-1:0]       rd_idx;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [PIXEL_WIDTH-1:0]  rd_pixel;
   int                      rd_sel;

   // Frame start outranks line start when both strobe together (no bank swap).
   assign ev_a     = newframe;
   assign ev_b     = newline && visible_line && !newframe;
   assign ev_any   = ev_a || ev_b;
   assign nxt_base = ev_a ? fb_base : base_q;
   assign nxt_row  = ev_a ? '0 : (ev_b ? fetch_row + ROW_W'(1) : fetch_row);
   assign nxt_bank = ev_a ? 1'b0 : (ev_b ? ~fetch_bank : fetch_bank);
   assign ev_start = ev_a || (ev_b && (nxt_row < v_active));
   assign row_addr = nxt_base + ADDR_WIDTH'(nxt_row) * ADDR_WIDTH'(WORDS_PER_LINE);

   assign ack       = (state == FETCH) && mem.mem_ack;
   assign last_word = (word_idx == WIDX_W'(WORDS_PER_LINE - 1));
   assign launch    = (state != FETCH) && ev_start;
   // A late start lets the outstanding word complete, then restarts from word 0.
   assign restart   = ack && (ev_any ? ev_start : (abort_pend && start_pend));
   assign burst_end = ack && (last_word || ev_any || abort_pend);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE, DONE: if (ev_start) state_nxt = FETCH;
         FETCH: begin
            if (restart)        state_nxt = FETCH;
            else if (burst_end) state_nxt = DONE;
         end
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem.mem_req  = (state == FETCH);
      mem.mem_addr = addr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         addr_q       <= '0;
         word_idx     <= '0;
         burst_bank   <= 1'b0;
         abort_pend   <= 1'b0;
         start_pend   <= 1'b0;
         base_q       <= '0;
         fetch_row    <= '0;
         fetch_bank   <= 1'b0;
         display_bank <= 1'b1;
         underrun     <= 1'b0;
      end else begin
         if (launch || restart) begin
            addr_q     <= row_addr;
            word_idx   <= '0;
            burst_bank <= nxt_bank;
         end else if (ack) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            word_idx <= word_idx + WIDX_W'(1);
         end

         if (ack || launch) begin
            abort_pend <= 1'b0;
         end else if (state == FETCH && ev_any) begin
            abort_pend <= 1'b1;
            start_pend <= ev_start;
         end

         base_q     <= nxt_base;
         fetch_row  <= nxt_row;
         fetch_bank <= nxt_bank;
         if (ev_b) display_bank <= fetch_bank;

         if (ev_a)                         underrun <= 1'b0;
         else if (ev_b && state == FETCH)  underrun <= 1'b1;
      end
   end

   // NOTE: the line buffer holds only data and is never read before written, so it has no reset.
   always_ff @(posedge clk) begin
      if (ack) line_buf[{burst_bank, word_idx}] <= mem.mem_rdata;
   end

   always_comb begin
      rd_idx   = WIDX_W'(pixel_x / PX_W'(PIX_PER_WORD));
      rd_sel   = int'(pixel_x % PX_W'(PIX_PER_WORD));
      rd_word  = line_buf[{display_bank, rd_idx}];
      rd_pixel = rd_word[rd_sel*PIXEL_WIDTH +: PIXEL_WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_x     <= '0;
         pixel       <= '0;
         pixel_valid <= 1'b0;
      end else begin
         if (ev_b) begin
            pixel_x <= '0;
         end else if (newpixel && visible_window &&
                      pixel_x != PX_W'(PIXELS_PER_LINE - 1)) begin
            pixel_x <= pixel_x + PX_W'(1);
         end

         pixel_valid <= newpixel && visible_window;
         if (newpixel && visible_window) pixel <= rd_pixel;
         else if (!visible_window)       pixel <= '0;
      end
   end

endmodule

// File: tb/tb_line_prefetch_reader.sv
// Directed bench for line_prefetch_reader: memory responder with address scoreboard,
// pixel scoreboard fed at each strobe, and a small line/row model.
module tb_line_prefetch_reader;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int PW  = 8;
  localparam int PPL = 256;
  localparam int WPL = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          newframe = 1'b0, newline = 1'b0, newpixel = 1'b0;
  logic          visible_line = 1'b0, visible_window = 1'b0;
  logic [8:0]    v_active = 9'd4;
  logic [AW-1:0] fb_base = 16'h1000;
  logic [PW-1:0] pixel;
  logic          pixel_valid, underrun;

  always #5 clk = ~clk;

  line_prefetch_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  line_prefetch_reader #(
    .PIXELS_PER_LINE(PPL), .PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .newframe(newframe), .newline(newline), .newpixel(newpixel),
    .visible_line(visible_line), .visible_window(visible_window), .v_active(v_active),
    .fb_base(fb_base), .mem(mem_if), .pixel(pixel), .pixel_valid(pixel_valid),
    .underrun(underrun)
  );

  int            n_cmp = 0, n_err = 0;
  logic [AW-1:0] addr_q [$];
  logic [PW-1:0] pix_q [$];
  int            ack_period = 0, ack_cnt = 0, n_acks = 0, n_bursts = 0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] base_m = 16'h1000;
  int            fetch_row_m = 0, disp_row_m = 0, px_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: pixel 2w+1 / 2w+2 per word, tagged with the row bits of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    logic [7:0] t, lo, hi;
    t  = {a[10:7], 4'b0};
    lo = 8'(2 * a[6:0] + 1) ^ t;
    hi = 8'(2 * a[6:0] + 2) ^ t;
    return {hi, lo};
  endfunction

  function automatic logic [PW-1:0] pix_fn(input logic [AW-1:0] row_addr, input int px);
    logic [DW-1:0] w;
    w = mem_fn(row_addr + 16'(px / 2));
    return (px % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  task automatic push_row(input logic [AW-1:0] first, input int count);
    for (int i = 0; i < count; i++) addr_q.push_back(first + 16'(i));
  endtask

  // One clock: drive strobes and memory response at negedge, sample at the next negedge.
  task automatic cycle(input logic nf, input logic nl, input logic np, input logic vl,
                       input logic vw);
    logic exp_valid;
    newframe = nf; newline = nl; newpixel = np; visible_line = vl; visible_window = vw;
    ack_cnt++;
    if (mem_if.mem_req === 1'b1 && ack_period != 0 && ack_cnt >= ack_period) begin
      mem_if.mem_ack   = 1'b1;
      mem_if.mem_rdata = mem_fn(mem_if.mem_addr);
      ack_cnt = 0;
      n_acks++;
      if (addr_q.size() > 0) check("mem_addr", 32'(mem_if.mem_addr), 32'(addr_q.pop_front()));
    end else begin
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = '0;
    end
    exp_valid = np && vw;
    if (exp_valid) begin
      pix_q.push_back(pix_fn(base_m + 16'(disp_row_m * WPL), px_m));
      if (px_m < PPL - 1) px_m++;
    end
    if (nf) begin
      base_m = fb_base;
      fetch_row_m = 0;
    end else if (nl && vl) begin
      disp_row_m = fetch_row_m;
      fetch_row_m++;
      px_m = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check("pixel_valid", 32'(pixel_valid), 32'(exp_valid));
    if (pixel_valid === 1'b1 && pix_q.size() > 0) check("pixel", 32'(pixel), 32'(pix_q.pop_front()));
    if (mem_if.mem_req === 1'b1 && !prev_req) n_bursts++;
    prev_req = (mem_if.mem_req === 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag, input int limit);
    int i;
    i = 0;
    while (addr_q.size() != 0 && i < limit) begin
      idle(1);
      i++;
    end
    check(tag, 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of a burst drops the request immediately.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("t1_req_up", 32'(mem_if.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_req_async", 32'(mem_if.mem_req), 32'd0);
    check("t1_addr", 32'(mem_if.mem_addr), 32'd0);
    check("t1_underrun", 32'(underrun), 32'd0);
    check("t1_pixel", 32'(pixel), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_row_m = 0;
    prev_req = 1'b0;
    idle(2);
    check("t1_idle_after", 32'(mem_if.mem_req), 32'd0);

    // Full-speed burst of row 0.
    ack_period = 1;
    n_acks = 0;
    push_row(16'h1000, WPL);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("t2_drain", 400);
    idle(2);
    check("t2_req_low", 32'(mem_if.mem_req), 32'd0);
    check("t2_acks", 32'(n_acks), 32'd128);

    // Swap to row 0 and show two pixels while row 1 trickles in slowly.
    ack_period = 20;
    n_acks = 0;
    push_row(16'h1080, 6);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3_pix0", 32'(pixel), 32'h01);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3_pix1", 32'(pixel), 32'h02);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_blank", 32'(pixel), 32'd0);
    for (int i = 0; i < 400 && n_acks < 6; i++) idle(1);
    check("t3_acks", 32'(n_acks), 32'd6);

    // Late line start: outstanding word completes, then row 2 restarts from word 0.
    addr_q.push_back(16'h1086);
    push_row(16'h1100, WPL);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_underrun", 32'(underrun), 32'd1);
    ack_period = 1;
    drain("t4_drain", 400);
    idle(2);
    check("t4_req_low", 32'(mem_if.mem_req), 32'd0);

    // 300 strobes on row 2: pixel index saturates at the last pixel.
    push_row(16'h1180, WPL);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t6_last_pixel", 32'(pixel), 32'(pix_fn(16'h1100, PPL - 1)));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("t6_drain", 400);
    check("t6_pix_q_empty", 32'(pix_q.size()), 32'd0);
    check("t6_underrun_sticky", 32'(underrun), 32'd1);

    // Two active lines per field: only two bursts; newframe clears underrun.
    v_active = 9'd2;
    n_bursts = 0;
    push_row(16'h1000, WPL);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_underrun_clr", 32'(underrun), 32'd0);
    drain("t5_drain0", 400);
    push_row(16'h1080, WPL);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drain("t5_drain1", 400);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(20);
    check("t5_req_low", 32'(mem_if.mem_req), 32'd0);
    check("t5_bursts", 32'(n_bursts), 32'd2);
    check("t5_underrun", 32'(underrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
